u712_bus_sizer: RTL and testbench
=================================

Name: u712_bus_sizer

Overview:
- Parametrised dynamic bus-sizing sequencer that follows the combinational byte-enable decode.
- Accepts one CPU operand request (byte, word, long or line, 68040 SIZ encoding) at any start offset.
- Splits the request into a sequence of port-aligned beats for a narrower target port (16-bit chipset or 8-bit I/O), driving per-beat host byte-lane enables and low address.
- Handshakes each beat with the target and reports completion or error back to the cycle controller.

Parameters:
- HOST_BYTES, 4, host data bus width in bytes (power of 2, 2..8).
- PORT_BYTES, 2, target port width in bytes (power of 2, 1..HOST_BYTES).
- TIMEOUT, 64, max clocks in WAIT before a beat is declared failed (≥2).

Ports:
- CLK40  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  1  request strobe, sampled only in IDLE.
- SIZ  input  2  operand size: 00 long(4), 01 byte(1), 10 word(2), 11 line(16 bytes).
- A  input  4  operand start address low bits.
- BUSY  output  1  sequence in progress.
- PORT_START  output  1  one-clock pulse at the start of each beat.
- PORT_A  output  4  low address of the current beat, held from START until the beat ends.
- PORT_BEn  output  HOST_BYTES  active-low lane enables; bit i = byte at offset i mod HOST_BYTES (bit 0 = most significant lane, D31:24 at 32 bits).
- PORT_ACK  input  1  beat completed by the target.
- PORT_BERR  input  1  beat failed at the target.
- DONE  output  1  one-clock pulse ending the sequence.
- ERR  output  1  valid with DONE: sequence aborted (BERR or timeout).

Behaviour:
- Reset values: BUSY=0, PORT_START=0, PORT_A=0, PORT_BEn=all ones, DONE=0, ERR=0, state=IDLE, counters=0.
- RESET asserted in any state aborts immediately to the reset values. No DONE is issued.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: REQ=1 at edge k latches SIZ and A.
  - Sets remaining = length(SIZ) and addr = A. For a line, addr = {A[3:2],2'b00}.
  - Next state ISSUE, BUSY=1 from cycle k+1.
- ISSUE: lasts one clock. PORT_START=1.
  - chunk = min(remaining, PORT_BYTES - (addr mod PORT_BYTES)).
  - PORT_A = addr.
  - PORT_BEn clears bits (addr mod HOST_BYTES) .. +chunk-1. All other bits stay 1.
  - Next state WAIT. The ACK/BERR inputs are ignored in ISSUE.
- WAIT: PORT_A and PORT_BEn hold. The timeout counter increments each clock.
  - BERR=1 → FIN with ERR. BERR takes priority over a simultaneous ACK.
  - ACK=1 → addr += chunk (4-bit, wraps mod 16), remaining -= chunk, counter cleared.
    - If remaining = 0 → FIN.
    - Otherwise → ISSUE on the next clock.
  - Counter reaches TIMEOUT with no ACK/BERR → FIN with ERR.
- FIN: DONE=1 for one clock. ERR=1 that clock if the sequence aborted, else 0.
  - PORT_BEn returns to all ones, BUSY=0.
  - Next state IDLE. No further PORT_START occurs after an abort.
- Latency: first PORT_START one clock after REQ is sampled. Each beat costs 1 clock plus the WAIT duration. DONE comes one clock after the final ACK.
- Any alignment is legal. A non-line operand crossing a HOST_BYTES boundary continues with addr incrementing mod 16, and lane indices wrap mod HOST_BYTES.
- A line always totals 16 bytes in 16/PORT_BYTES beats, wrapping modulo 16 from its aligned start.
- REQ while BUSY is ignored and is not queued.
- PORT_BYTES = HOST_BYTES with an aligned long gives a single beat.

Decomposition:
- Shared package u712_pkg holds:
  - SIZ encodings (SIZ_LONG, SIZ_BYTE, SIZ_WORD, SIZ_LINE).
  - The state enumeration.
  - A length-from-SIZ function.
- One natural sub-module, u712_lane_mask: combinational (addr, chunk) → PORT_BEn, parametrised by HOST_BYTES.

Test Plan (HOST_BYTES=4, PORT_BYTES=2, TIMEOUT=8):
- Long at A=0, ACK 2 clocks after each START → beats PORT_A=0 BEn=4'b1100 then PORT_A=2 BEn=4'b0011; DONE=1, ERR=0.
- Byte at A=3 → single beat PORT_A=3 BEn=4'b0111; DONE one clock after ACK.
- Word at A=1 → beats PORT_A=1 BEn=4'b1101 then PORT_A=2 BEn=4'b1011; remaining reaches 0, DONE.
- Line at A=6, ACK every beat → 8 beats, PORT_A=4,6,8,A,C,E,0,2, BEn alternating 1100/0011; DONE, ERR=0.
- Long at A=0, PORT_BERR and PORT_ACK together on beat 1 → no second START; DONE=1 with ERR=1 next clock.
- Word at A=0, no ACK → ERR with DONE after 8 WAIT clocks. Separate run: RESET pulsed mid-WAIT → all outputs at reset values immediately, no DONE; a new REQ afterwards starts cleanly.

Source files
------------

// File: rtl/u712_pkg.sv
// Shared definitions for the u712 dynamic bus sizer: 68040 SIZ codes,
// sequencer states and operand length decode.
package u712_pkg;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FIN
    } state_t;

    function automatic logic [4:0] siz_len(input logic [1:0] siz);
        logic [4:0] len;
        case (siz)
            SIZ_BYTE: len = 5'd1;
            SIZ_WORD: len = 5'd2;
            SIZ_LINE: len = 5'd16;
            default:  len = 5'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/u712_lane_mask.sv
// Active-low host lane enables for a beat of i_chunk bytes starting at i_addr;
// lane indices wrap modulo HOST_BYTES.
module u712_lane_mask #(
    parameter int HOST_BYTES = 4
) (
    input  logic [3:0]            i_addr,
    input  logic [3:0]            i_chunk,
    output logic [HOST_BYTES-1:0] o_ben
);

    genvar gi;
    generate
        for (gi = 0; gi < HOST_BYTES; gi++) begin : g_lane
            logic [3:0] w_off;
            // Distance of this lane from the beat's first lane, modulo HOST_BYTES.
            assign w_off       = (4'(gi) - i_addr) & 4'(HOST_BYTES - 1);
            assign o_ben[gi]   = (w_off >= i_chunk);
        end
    endgenerate

endmodule

// File: rtl/u712_bus_sizer.sv
// Splits one CPU operand request into port-aligned beats for a narrower
// target port and handshakes each beat, reporting DONE/ERR at the end.
module u712_bus_sizer
    import u712_pkg::*;
#(
    parameter int HOST_BYTES = 4,
    parameter int PORT_BYTES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK40,
    input  logic                  RESET,
    input  logic                  REQ,
    input  logic [1:0]            SIZ,
    input  logic [3:0]            A,
    output logic                  BUSY,
    output logic                  PORT_START,
    output logic [3:0]            PORT_A,
    output logic [HOST_BYTES-1:0] PORT_BEn,
    input  logic                  PORT_ACK,
    input  logic                  PORT_BERR,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                r_state;
    logic [3:0]            r_addr;
    logic [4:0]            r_rem;
    logic [3:0]            r_chunk;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_start;
    logic [3:0]            r_port_a;
    logic [HOST_BYTES-1:0] r_ben;
    logic                  r_done;
    logic                  r_err;

    logic [3:0]            w_naddr;
    logic [4:0]            w_nrem;
    logic [4:0]            w_room;
    logic [3:0]            w_nchunk;
    logic [HOST_BYTES-1:0] w_mask;

    // Address/remaining of the next beat: from the request in IDLE, else advanced past the current beat.
    always_comb begin
        w_naddr = r_addr + r_chunk;
        w_nrem  = r_rem - {1'b0, r_chunk};
        if (r_state == ST_IDLE) begin
            w_naddr = (SIZ == SIZ_LINE) ? {A[3:2], 2'b00} : A;
            w_nrem  = siz_len(SIZ);
        end
    end

    assign w_room   = 5'(PORT_BYTES) - {1'b0, (w_naddr & 4'(PORT_BYTES - 1))};
    assign w_nchunk = (w_nrem < w_room) ? w_nrem[3:0] : w_room[3:0];

    u712_lane_mask #(
        .HOST_BYTES(HOST_BYTES)
    ) u_lane_mask (
        .i_addr (w_naddr),
        .i_chunk(w_nchunk),
        .o_ben  (w_mask)
    );

    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_chunk  <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_port_a <= '0;
            r_ben    <= '1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (REQ) begin
                        r_state  <= ST_ISSUE;
                        r_busy   <= 1'b1;
                        r_start  <= 1'b1;
                        r_addr   <= w_naddr;
                        r_rem    <= w_nrem;
                        r_chunk  <= w_nchunk;
                        r_port_a <= w_naddr;
                        r_ben    <= w_mask;
                        r_cnt    <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (PORT_BERR) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ben   <= '1;
                        r_cnt   <= '0;
                    end else if (PORT_ACK) begin
                        r_cnt  <= '0;
                        r_addr <= w_naddr;
                        r_rem  <= w_nrem;
                        if (w_nrem == 5'd0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_ben   <= '1;
                        end else begin
                            r_state  <= ST_ISSUE;
                            r_start  <= 1'b1;
                            r_chunk  <= w_nchunk;
                            r_port_a <= w_naddr;
                            r_ben    <= w_mask;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ben   <= '1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY       = r_busy;
    assign PORT_START = r_start;
    assign PORT_A     = r_port_a;
    assign PORT_BEn   = r_ben;
    assign DONE       = r_done;
    assign ERR        = r_err;

endmodule

// File: tb/tb_u712_bus_sizer.sv
// Scoreboard bench for u712_bus_sizer: beats are predicted by walking the
// operand byte by byte and grouping bytes that share a port-aligned word.
module tb_u712_bus_sizer;

    localparam int H = 4;
    localparam int P = 2;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [1:0]   siz;
    logic [3:0]   a;
    logic         ack;
    logic         berr;
    logic         busy;
    logic         port_start;
    logic [3:0]   port_a;
    logic [H-1:0] port_ben;
    logic         done;
    logic         err;

    u712_bus_sizer #(
        .HOST_BYTES(H),
        .PORT_BYTES(P),
        .TIMEOUT   (T)
    ) dut (
        .CLK40     (clk),
        .RESET     (rst),
        .REQ       (req),
        .SIZ       (siz),
        .A         (a),
        .BUSY      (busy),
        .PORT_START(port_start),
        .PORT_A    (port_a),
        .PORT_BEn  (port_ben),
        .PORT_ACK  (ack),
        .PORT_BERR (berr),
        .DONE      (done),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [H-1:0] ben;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_beats[$];
    bit    exp_done[$];
    beat_t plan[$];
    beat_t mon_bt;
    bit    mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the operand bytes; a new beat opens at the first byte and at every port-aligned byte.
    task automatic build_plan(input logic [1:0] s, input logic [3:0] aa);
        int    len;
        int    start;
        int    b;
        beat_t bt;
        plan.delete();
        case (s)
            2'b01:   len = 1;
            2'b10:   len = 2;
            2'b11:   len = 16;
            default: len = 4;
        endcase
        start   = (s == 2'b11) ? (int'(aa) / 4) * 4 : int'(aa);
        bt.addr = '0;
        bt.ben  = '1;
        for (int i = 0; i < len; i++) begin
            b = (start + i) % 16;
            if (i == 0 || (b % P) == 0) begin
                if (i != 0) plan.push_back(bt);
                bt.addr = 4'(b);
                bt.ben  = '1;
            end
            bt.ben[b % H] = 1'b0;
        end
        plan.push_back(bt);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (port_start) begin
                if (exp_beats.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: PORT_A=%0h with no beat expected at %0t", port_a, $time);
                end else begin
                    mon_bt = exp_beats.pop_front();
                    check("beat_addr", 32'(port_a), 32'(mon_bt.addr));
                    check("beat_ben", 32'(port_ben), 32'(mon_bt.ben));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: ERR=%0b with no completion expected at %0t", err, $time);
                end else begin
                    mon_e = exp_done.pop_front();
                    check("done_err", 32'(err), 32'(mon_e));
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_ben", 32'(port_ben), 32'({H{1'b1}}));
                end
            end
        end
    end

    // mode 0: ACK every beat; 1: BERR on abort_beat; 2: no response on abort_beat.
    task automatic run_txn(input logic [1:0] s, input logic [3:0] aa, input int mode, input int abort_beat);
        int n;
        int last;
        int d;
        build_plan(s, aa);
        n    = plan.size();
        last = (mode == 0) ? n - 1 : ((abort_beat >= n) ? n - 1 : abort_beat);
        for (int i = 0; i <= last; i++) exp_beats.push_back(plan[i]);
        exp_done.push_back(mode != 0);
        $display("txn siz=%0d a=%0h mode=%0d beats=%0d", s, aa, mode, last + 1);

        @(negedge clk);
        siz = s;
        a   = aa;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("start_latency", 32'(port_start), 32'd1);
        check("busy_set", 32'(busy), 32'd1);

        for (int i = 0; i <= last; i++) begin
            for (int k = 0; k < 20 && !port_start; k++) @(negedge clk);
            if (!port_start) begin
                check("start_wait_bound", 32'(port_start), 32'd1);
                break;
            end
            if (i == last && mode == 2) begin
                repeat (T) begin
                    @(negedge clk);
                    req = 1'($urandom_range(0, 1));
                end
                check("timeout_early", 32'(done), 32'd0);
                @(negedge clk);
                req = 1'b0;
                check("timeout_done", 32'(done), 32'd1);
            end else begin
                d = $urandom_range(0, 3);
                repeat (d + 1) begin
                    @(negedge clk);
                    req = 1'($urandom_range(0, 1));
                    siz = 2'($urandom_range(0, 3));
                    a   = 4'($urandom_range(0, 15));
                end
                if (i == last && mode == 1) begin
                    berr = 1'b1;
                    ack  = 1'b1;
                end else begin
                    ack = 1'b1;
                end
                @(negedge clk);
                ack  = 1'b0;
                berr = 1'b0;
                if (i == last) begin
                    req = 1'b0;
                    check("done_latency", 32'(done), 32'd1);
                end
            end
        end
        req = 1'b0;
        for (int k = 0; k < 40 && (busy || done); k++) @(negedge clk);
        check("idle_after", 32'({busy, done}), 32'd0);
    endtask

    task automatic reset_mid_wait();
        build_plan(2'b00, 4'h0);
        exp_beats.push_back(plan[0]);
        $display("txn reset mid-wait");
        @(negedge clk);
        siz = 2'b00;
        a   = 4'h0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("rst_start", 32'(port_start), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_clr", 32'(port_start), 32'd0);
        check("rst_port_a", 32'(port_a), 32'd0);
        check("rst_ben", 32'(port_ben), 32'({H{1'b1}}));
        check("rst_done", 32'({done, err}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_queue_empty", 32'(exp_beats.size()), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        siz  = 2'b00;
        a    = 4'h0;
        ack  = 1'b0;
        berr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_start", 32'(port_start), 32'd0);
        check("reset_port_a", 32'(port_a), 32'd0);
        check("reset_ben", 32'(port_ben), 32'({H{1'b1}}));
        check("reset_done_err", 32'({done, err}), 32'd0);
        #2 rst = 1'b0;

        run_txn(2'b00, 4'h0, 0, 0);
        run_txn(2'b01, 4'h3, 0, 0);
        run_txn(2'b10, 4'h1, 0, 0);
        run_txn(2'b11, 4'h6, 0, 0);
        run_txn(2'b00, 4'h0, 1, 0);
        run_txn(2'b10, 4'h0, 2, 0);
        reset_mid_wait();
        run_txn(2'b00, 4'h2, 0, 0);

        for (int t = 0; t < 60; t++) begin
            int m;
            int r;
            r = $urandom_range(0, 9);
            m = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
            run_txn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), m, $urandom_range(0, 7));
        end

        repeat (4) @(negedge clk);
        check("beats_drained", 32'(exp_beats.size()), 32'd0);
        check("dones_drained", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
